booth_mul_seq: RTL and testbench

Sequential radix-4 Booth multiplier for the MDU. It sits directly upstream of `booth_enc`. Each cycle it scans three multiplier bits and feeds them to the encoder as `code`. It then turns the encoder's `neg/zero/one/two` into a partial product and accumulates it. It serves the EXU for MUL/MULH/MULHSU/MULHU: operands go in over a valid/ready handshake, and the full 2·XLEN-bit product comes out over a second valid/ready handshake.

---
 rtl/mdu_pkg.sv | 18 +
 rtl/booth_enc.sv | 32 +++
 rtl/booth_mul_seq.sv | 143 ++++++++++++++
 tb/tb_booth_mul_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: multiplier FSM states, default operand width and
// the radix-4 Booth digit count.
package mdu_pkg;

    localparam int unsigned XLEN_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // One extra digit covers the sign/extension bits of the widened multiplier.
    function automatic int unsigned booth_digits(input int unsigned xlen);
        return xlen / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_enc.sv
// Radix-4 Booth encoder: maps a scanned 3-bit multiplier group
// {y[2i+1], y[2i], y[2i-1]} to a signed digit in {-2,-1,0,+1,+2}.
module booth_enc (
    input  logic [2:0] code_i,
    output logic       neg_c_o,
    output logic       zero_c_o,
    output logic       one_c_o,
    output logic       two_c_o
);

    always_comb begin
        neg_c_o  = 1'b0;
        zero_c_o = 1'b0;
        one_c_o  = 1'b0;
        two_c_o  = 1'b0;
        case (code_i)
            3'b000, 3'b111: zero_c_o = 1'b1;
            3'b001, 3'b010: one_c_o  = 1'b1;
            3'b011:         two_c_o  = 1'b1;
            3'b100: begin
                two_c_o = 1'b1;
                neg_c_o = 1'b1;
            end
            3'b101, 3'b110: begin
                one_c_o = 1'b1;
                neg_c_o = 1'b1;
            end
            default: zero_c_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one digit per cycle, full 2*XLEN
// product delivered over a valid/ready handshake.
module booth_mul_seq
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [XLEN-1:0]   src1_i,
    input  logic [XLEN-1:0]   src2_i,
    input  logic              src1_signed_i,
    input  logic              src2_signed_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [2*XLEN-1:0] product_o
);

    localparam int unsigned NDIG   = booth_digits(XLEN);
    localparam int unsigned CNT_W  = $clog2(NDIG);
    localparam int unsigned ACC_W  = 2 * XLEN + 2;
    localparam int unsigned MQ_W   = XLEN + 3;
    localparam int unsigned PROD_W = 2 * XLEN;

    mul_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   mcand_q, mcand_d;
    logic [MQ_W-1:0]    mplier_q, mplier_d;
    logic [PROD_W-1:0]  product_q, product_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               enc_neg, enc_zero, enc_one, enc_two;
    logic [ACC_W-1:0]   pp;
    logic [ACC_W-1:0]   pp_add;
    logic [ACC_W-1:0]   x_ext;
    logic [MQ_W-1:0]    y_ext;

    // Operand widening; the multiplier gets the implicit y[-1]=0 appended.
    assign x_ext = {{(ACC_W - XLEN){src1_signed_i & src1_i[XLEN-1]}}, src1_i};
    assign y_ext = {{2{src2_signed_i & src2_i[XLEN-1]}}, src2_i, 1'b0};

    booth_enc u_booth_enc (
        .code_i   (mplier_q[2:0]),
        .neg_c_o  (enc_neg),
        .zero_c_o (enc_zero),
        .one_c_o  (enc_one),
        .two_c_o  (enc_two)
    );

    // mcand_q is pre-shifted by 2i, so pp is already aligned to the digit weight.
    always_comb begin
        pp = '0;
        if (enc_zero) begin
            pp = '0;
        end else if (enc_two) begin
            pp = mcand_q << 1;
        end else if (enc_one) begin
            pp = mcand_q;
        end
        pp_add = pp ^ {ACC_W{enc_neg}};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        product_d = product_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d  = BUSY;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = x_ext;
                    mplier_d = y_ext;
                end
            end
            BUSY: begin
                // Negation completes via the +1 carried into the same add.
                acc_d    = acc_q + pp_add + ACC_W'(enc_neg);
                mcand_d  = mcand_q << 2;
                mplier_d = {{2{mplier_q[MQ_W-1]}}, mplier_q[MQ_W-1:2]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NDIG - 1)) begin
                    state_d   = DONE;
                    cnt_d     = '0;
                    product_d = acc_d[PROD_W-1:0];
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect wins over both handshakes; a result in DONE is dropped.
        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign product_o   = product_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq: hand-computed products, latency,
// back-pressure, flush and asynchronous reset behaviour.
module tb_booth_mul_seq;

    localparam int unsigned XLEN = 64;
    localparam int LAT = 33;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic              s1;
    logic              s2;
    logic              out_valid;
    logic              out_ready;
    logic [2*XLEN-1:0] product;

    int errors = 0;
    int checks = 0;
    int cyc;
    logic busy_rdy;
    logic seen_valid;

    booth_mul_seq #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .src1_i        (src1),
        .src2_i        (src2),
        .src1_signed_i (s1),
        .src2_signed_i (s2),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .product_o     (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands for one accept edge; returns at the following negedge
    // with junk operands and in_valid still high to show they are ignored.
    task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                            input logic sa, input logic sb);
        @(negedge clk);
        src1 = a; src2 = b; s1 = sa; s2 = sb; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        src1 = ~a; src2 = ~b; s1 = ~sa; s2 = ~sb;
    endtask

    // Count edges after the accept edge until out_valid, bounded.
    task automatic wait_done(output int n, output logic rdy_bad);
        n = 0;
        rdy_bad = (in_ready !== 1'b0);
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            in_valid = 1'b0;
            if (out_valid !== 1'b1 && in_ready !== 1'b0) rdy_bad = 1'b1;
        end
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ovalid_drop"}, 128'(out_valid), 128'd0);
        check({tag, "_inready_back"}, 128'(in_ready), 128'd1);
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic sa, input logic sb, input logic [127:0] exp);
        start_op(a, b, sa, sb);
        wait_done(cyc, busy_rdy);
        check({tag, "_latency"}, 128'(cyc), 128'(LAT));
        check({tag, "_product"}, product, exp);
        finish_op(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        src1 = '0; src2 = '0; s1 = 1'b0; s2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_product", product, 128'd0);
        rst = 1'b0;

        // Unsigned 3 x 5 with latency and in_ready during BUSY
        start_op(64'd3, 64'd5, 1'b0, 1'b0);
        wait_done(cyc, busy_rdy);
        check("u3x5_latency", 128'(cyc), 128'(LAT));
        check("u3x5_inready_busy", 128'(busy_rdy), 128'd0);
        check("u3x5_product", product, 128'd15);
        finish_op("u3x5");

        run_op("s_m3x7", 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 1'b1, 1'b1,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB);
        run_op("mulhsu", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
               128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001);
        run_op("s_m1xm1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1,
               128'd1);
        run_op("s_minxmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b1,
               128'h4000_0000_0000_0000_0000_0000_0000_0000);
        run_op("u_minx2", 64'h8000_0000_0000_0000, 64'd2, 1'b0, 1'b0,
               128'h0000_0000_0000_0001_0000_0000_0000_0000);
        run_op("zero", 64'd0, 64'hDEAD_BEEF_1234_5678, 1'b1, 1'b1, 128'd0);

        // Unsigned max squared, held under back-pressure
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        wait_done(cyc, busy_rdy);
        check("umax_latency", 128'(cyc), 128'(LAT));
        for (int k = 0; k < 5; k++) begin
            check("bp_product", product, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
            check("bp_out_valid", 128'(out_valid), 128'd1);
            @(posedge clk);
            @(negedge clk);
        end
        finish_op("bp");

        // Flush at cnt=10: no result, then a clean 6 x 7
        start_op(64'd1234, 64'd5678, 1'b0, 1'b0);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", 128'(in_ready), 128'd1);
        seen_valid = out_valid;
        repeat (40) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid !== 1'b0) seen_valid = 1'b1;
        end
        check("flush_no_valid", 128'(seen_valid), 128'd0);
        run_op("after_flush_6x7", 64'd6, 64'd7, 1'b0, 1'b0, 128'd42);

        // Flush together with out_ready in DONE drops the result
        start_op(64'd9, 64'd9, 1'b0, 1'b0);
        wait_done(cyc, busy_rdy);
        check("fdone_product", product, 128'd81);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b0;
        check("fdone_out_valid", 128'(out_valid), 128'd0);
        check("fdone_in_ready", 128'(in_ready), 128'd1);

        // Asynchronous reset mid-BUSY
        start_op(64'd11, 64'd13, 1'b0, 1'b0);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("arst_in_ready", 128'(in_ready), 128'd1);
        check("arst_out_valid", 128'(out_valid), 128'd0);
        check("arst_product", product, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after_rst_11x13", 64'd11, 64'd13, 1'b0, 1'b0, 128'd143);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
